// File: rtl/key_search_pkg.sv
// Shared types and helpers for the RC4 key-search scheduler.
package key_search_pkg;

   localparam int KEY_W = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FOUND,
      S_EXHAUSTED
   } ks_state_t;

   function automatic logic [KEY_W-1:0] min_key(input logic [KEY_W-1:0] a,
                                                 input logic [KEY_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/key_search_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at the core after the last grant.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         grant_ack,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          got;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      got   = 1'b0;
      // scan from the pointer upward first, then wrap to the cores below it
      for (int i = 0; i < N; i++) begin
         if (!got && req[i] && (i >= int'(ptr_q))) begin
            gnt[i] = 1'b1;
            got    = 1'b1;
            ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!got && req[i] && (i < int'(ptr_q))) begin
            gnt[i] = 1'b1;
            got    = 1'b1;
            ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (grant_ack) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/key_search_ctrl.sv
// Key-space walker feeding NUM_CORES decrypt cores; stops on a valid key or exhaustion.
module key_search_ctrl
   import key_search_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int KEY_BITS  = 22
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [NUM_CORES-1:0]      core_start,
   output logic [NUM_CORES*24-1:0]   core_key,
   input  logic [NUM_CORES-1:0]      core_done,
   input  logic [NUM_CORES-1:0]      core_valid,
   output logic                      busy,
   output logic                      found,
   output logic                      exhausted,
   output logic [23:0]               found_key
);

   ks_state_t                       state_q, state_d;
   logic [KEY_BITS-1:0]             next_key_q, next_key_d;
   logic [NUM_CORES-1:0]            busy_q, busy_d;
   logic                            hit_q, hit_d;
   logic [KEY_W-1:0]                found_key_q, found_key_d;
   logic [NUM_CORES-1:0][KEY_W-1:0] core_key_q, core_key_d;
   logic [NUM_CORES-1:0]            hits, req, gnt;
   logic                            dispatch, last_key;

   // only completions from cores we actually launched count
   assign hits     = core_done & core_valid & busy_q;
   assign req      = (state_q == S_RUN && hits == '0) ? ~busy_q : '0;
   assign dispatch = |gnt;
   assign last_key = &next_key_q;

   rr_arbiter #(.N(NUM_CORES)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant_ack (dispatch),
      .gnt       (gnt)
   );

   always_comb begin
      state_d     = state_q;
      next_key_d  = next_key_q;
      busy_d      = (busy_q & ~core_done) | gnt;
      hit_d       = hit_q;
      found_key_d = found_key_q;
      core_key_d  = core_key_q;

      for (int i = 0; i < NUM_CORES; i++) begin
         if (gnt[i]) core_key_d[i] = KEY_W'(next_key_q);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (hits[i]) begin
            found_key_d = hit_d ? min_key(found_key_d, core_key_q[i]) : core_key_q[i];
            hit_d       = 1'b1;
         end
      end
      // the last key is dispatched at most once; the counter parks there
      if (dispatch && !last_key) next_key_d = next_key_q + 1'b1;

      case (state_q)
         S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (start) begin
               state_d     = S_RUN;
               next_key_d  = '0;
               busy_d      = '0;
               hit_d       = 1'b0;
               found_key_d = '0;
            end
         end
         S_RUN: begin
            if (hit_d || (dispatch && last_key)) begin
               if (busy_d == '0) state_d = hit_d ? S_FOUND : S_EXHAUSTED;
               else              state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (busy_d == '0) state_d = hit_d ? S_FOUND : S_EXHAUSTED;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         next_key_q  <= '0;
         busy_q      <= '0;
         hit_q       <= 1'b0;
         found_key_q <= '0;
         core_key_q  <= '0;
      end else begin
         state_q     <= state_d;
         next_key_q  <= next_key_d;
         busy_q      <= busy_d;
         hit_q       <= hit_d;
         found_key_q <= found_key_d;
         core_key_q  <= core_key_d;
      end
   end

   assign core_start = gnt;
   assign core_key   = core_key_d;
   assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign found      = (state_q == S_FOUND);
   assign exhausted  = (state_q == S_EXHAUSTED);
   assign found_key  = found_key_q;

endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Scheduler for the RC4 key-search datapath. It walks the 22-bit key space and hands candidate keys to `NUM_CORES` parallel decrypt/check cores through a per-core start/done handshake, so that all cores stay busy. It collects each core's verdict and stops when a valid key is found or the key space is exhausted. It sits between the top-level control (switches/LEDs/HEX) and the replicated decrypt cores, and replaces the single-core key generator loop.

## Interface
Parameters:
- `NUM_CORES`, 2: number of decrypt cores; range 1..8.
- `KEY_BITS`, 22: searched key bits. Keys are zero-extended to 24 bits.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a new search; level sampled each cycle, acted on only in IDLE, FOUND or EXHAUSTED.
- `core_start`  out  NUM_CORES  one-cycle pulse launching core i.
- `core_key`  out  NUM_CORES×24  key for core i; valid from the `core_start` cycle and held until the next dispatch to that core.
- `core_done`  in  NUM_CORES  one-cycle pulse: core i has finished.
- `core_valid`  in  NUM_CORES  sampled with `core_done[i]`; 1 means the decrypted message passed the check.
- `busy`  out  1  search in progress (RUN or DRAIN).
- `found`  out  1  search ended with a valid key; held.
- `exhausted`  out  1  search ended with no valid key; held.
- `found_key`  out  24  winning key; meaningful while `found` is 1.

## Operation
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- Reset: state IDLE. `core_start`, `core_key`, `busy`, `found`, `exhausted` and `found_key` are all 0. `next_key` is 0 and all core-busy flags are clear.
- IDLE/FOUND/EXHAUSTED with `start`=1:
  - clear `next_key`, the busy flags, `found`, `exhausted`, `found_key` and the hit flag;
  - go to RUN.
- RUN, each cycle:
  - A round-robin arbiter selects one idle core. Priority rotates to the core after the last granted one.
  - The selected core gets `core_start[i]`=1 and `core_key[i]`={zeros, `next_key`}, and is marked busy.
  - `next_key` increments.
  - At most one dispatch happens per cycle.
- `core_done[i]` while core i is busy clears its busy flag.
- `core_done[i]` while core i is idle is ignored, including its `core_valid`.
- Result capture: `core_done[i]` with `core_valid[i]`=1 sets the hit flag. `found_key` takes the smallest key among this cycle's valid reporters and the current `found_key`, if one is already held.
- RUN → DRAIN when either:
  - the hit flag sets, or
  - key 2^KEY_BITS−1 is dispatched.
  - No dispatch occurs in the cycle the hit is captured or later.
- DRAIN: no dispatches. Valid results continue to update `found_key` under the smallest-key rule.
- DRAIN → FOUND or EXHAUSTED once all busy flags are clear:
  - FOUND if the hit flag is set;
  - EXHAUSTED otherwise.
- FOUND and EXHAUSTED hold their outputs until a new `start` or reset.
- `next_key` never wraps. After the last key is dispatched it is not used again.
- Reset mid-search returns to the reset values immediately. Cores are not aborted: late `core_done` pulses arrive when no core is busy and are therefore ignored.

## Timing
- `start` sampled in cycle T → state RUN at T+1. The first `core_start` pulse is at T+1 (combinational grant from registered state), registered out at T+1.
- Core freed by `core_done` at cycle T is eligible for dispatch at T+1, not T.
- Hit captured at T (from `core_done`/`core_valid` at T) → no `core_start` at T+1 or later. `found` is asserted the cycle after the last busy core completes.
  - If no other core is busy, `found`=1 at T+1.
- `busy` = 1 exactly in RUN and DRAIN.
- `found` and `exhausted` are mutually exclusive and never 1 while `busy`=1.

## Structure
- `key_search_pkg` holds:
  - the state enum `ks_state_t`;
  - `KEY_W`=24;
  - the helper function `min_key` used by result capture.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector (idle cores and RUN), `grant_ack`;
  - output: one-hot grant;
  - registered rotating priority pointer, reset to core 0.

## Test plan
- NUM_CORES=2, cores model a 5-cycle latency, valid only for key 0x000007 → dispatch order is 0(c0), 1(c1), 2(c0) and so on. `found`=1, `found_key`=0x000007. No key above the last dispatched key +0 is issued after the hit.
- KEY_BITS=4, cores never valid → keys 0..15 are each dispatched exactly once, then `exhausted`=1, `found`=0, `busy`=0. No wrap back to key 0.
- Simultaneous hits: keys 0x000009 (c1) and 0x000008 (c0) both report valid in the same cycle → `found_key`=0x000008.
- Late smaller hit in DRAIN: key 0x000010 hits first, then in-flight key 0x00000F reports valid → `found_key`=0x00000F.
- Core `done` at cycle T → that core receives no `core_start` at T, and may receive one at T+1. A spurious `core_done` to an idle core with `valid`=1 → no `found`.
- `rst_n` deasserted mid-RUN → all outputs are 0 asynchronously. After reset, a new `start` restarts from key 0.
